// File: rtl/neuron_scheduler.sv
// ---------------------------------------------------------------------------
// neuron_scheduler
//
// Sequences one neural-layer job through an external multi-cycle datapath.
// A job is a single input vector (A) that is combined with TILES weight
// tiles (B), one tile at a time:
//
//   IDLE  -> accept input vector into A, clear tile counter
//   FETCH -> request weight tile <tile>, wait for it, latch into B
//   ISSUE -> one-cycle datapath start pulse
//   WAIT  -> LATENCY cycles; the result is captured on the last edge
//   EMIT  -> present the tile result until downstream accepts it, then
//            either fetch the next tile or return to IDLE after the last
//
// All control outputs are flops loaded from the next-state decode, so
// they change only on clock edges and take their reset values as soon as
// RESET_N falls.
//
// Ports
//   CLOCK      in   rising-edge clock
//   RESET_N    in   asynchronous active-low reset
//   IN_VALID   in   job input vector valid
//   IN_READY   out  scheduler idle and able to accept a job
//   IN_DATA    in   job input vector            [DWIDTH*IDIM]
//   W_REQ      out  weight tile fetch request
//   W_ADDR     out  requested tile index        [max(1,clog2(TILES))]
//   W_VALID    in   weight tile returned (only honoured in FETCH)
//   W_DATA     in   weight tile                 [DWIDTH*ODIM]
//   DP_START   out  datapath start pulse
//   DP_A       out  datapath operand A          [DWIDTH*IDIM]
//   DP_B       out  datapath operand B          [DWIDTH*ODIM]
//   DP_O       in   datapath result             [DWIDTH*IDIM*ODIM]
//   OUT_VALID  out  tile result valid
//   OUT_READY  in   downstream accepts result
//   OUT_DATA   out  registered tile result      [DWIDTH*IDIM*ODIM]
//   OUT_TILE   out  tile index of OUT_DATA      [max(1,clog2(TILES))]
//   OUT_LAST   out  OUT_DATA is the final tile of the job
//   BUSY       out  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module neuron_scheduler #(
  parameter int DWIDTH  = 32,
  parameter int IDIM    = 1,
  parameter int ODIM    = 2,
  parameter int TILES   = 4,
  parameter int LATENCY = 4
) (
  input  logic                                         CLOCK,
  input  logic                                         RESET_N,
  input  logic                                         IN_VALID,
  output logic                                         IN_READY,
  input  logic [DWIDTH*IDIM-1:0]                       IN_DATA,
  output logic                                         W_REQ,
  output logic [((TILES > 1) ? $clog2(TILES) : 1)-1:0] W_ADDR,
  input  logic                                         W_VALID,
  input  logic [DWIDTH*ODIM-1:0]                       W_DATA,
  output logic                                         DP_START,
  output logic [DWIDTH*IDIM-1:0]                       DP_A,
  output logic [DWIDTH*ODIM-1:0]                       DP_B,
  input  logic [DWIDTH*IDIM*ODIM-1:0]                  DP_O,
  output logic                                         OUT_VALID,
  input  logic                                         OUT_READY,
  output logic [DWIDTH*IDIM*ODIM-1:0]                  OUT_DATA,
  output logic [((TILES > 1) ? $clog2(TILES) : 1)-1:0] OUT_TILE,
  output logic                                         OUT_LAST,
  output logic                                         BUSY
);

  localparam int TW = (TILES > 1) ? $clog2(TILES) : 1;
  localparam int LW = $clog2(LATENCY + 1);
  localparam int AW = DWIDTH * IDIM;
  localparam int BW = DWIDTH * ODIM;
  localparam int OW = DWIDTH * IDIM * ODIM;

  localparam logic [TW-1:0] LAST_TILE = TW'(TILES - 1);
  localparam logic [LW-1:0] LAT_LOAD  = LW'(LATENCY);
  localparam logic [LW-1:0] LAT_ONE   = LW'(1);
  localparam logic [TW-1:0] TILE_ONE  = TW'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_EMIT  = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_n;

  logic            accept_s;    // job handshake in IDLE
  logic            wtake_s;     // weight tile accepted in FETCH
  logic            capture_s;   // last WAIT cycle: capture DP_O
  logic            advance_s;   // non-final tile accepted downstream

  logic [AW-1:0]   a_r;
  logic [BW-1:0]   b_r;
  logic [TW-1:0]   tile_r;
  logic [LW-1:0]   lat_cnt_r;

  logic            in_ready_r;
  logic            busy_r;
  logic            w_req_r;
  logic            dp_start_r;
  logic            out_valid_r;
  logic [OW-1:0]   out_data_r;
  logic [TW-1:0]   out_tile_r;
  logic            out_last_r;

  // State register.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state decode and the single-cycle strobes that qualify datapath updates.
  always_comb begin
    state_n   = state_r;
    accept_s  = 1'b0;
    wtake_s   = 1'b0;
    capture_s = 1'b0;
    advance_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (IN_VALID) begin
          accept_s = 1'b1;
          state_n  = ST_FETCH;
        end else begin
          state_n  = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // Accepted on the entry cycle too, giving a zero-wait fetch.
        if (W_VALID) begin
          wtake_s = 1'b1;
          state_n = ST_ISSUE;
        end else begin
          state_n = ST_FETCH;
        end
      end
      ST_ISSUE: begin
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        // Counter was loaded with LATENCY on the ISSUE edge, so reaching
        // one marks the final WAIT cycle.
        if (lat_cnt_r == LAT_ONE) begin
          capture_s = 1'b1;
          state_n   = ST_EMIT;
        end else begin
          state_n   = ST_WAIT;
        end
      end
      ST_EMIT: begin
        if (OUT_READY) begin
          if (out_last_r) begin
            state_n   = ST_IDLE;
          end else begin
            advance_s = 1'b1;
            state_n   = ST_FETCH;
          end
        end else begin
          state_n = ST_EMIT;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Control outputs registered from the next state so they align with state_r.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      w_req_r     <= 1'b0;
      dp_start_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_n == ST_IDLE);
      busy_r      <= (state_n != ST_IDLE);
      w_req_r     <= (state_n == ST_FETCH);
      dp_start_r  <= (state_n == ST_ISSUE);
      out_valid_r <= (state_n == ST_EMIT);
    end
  end

  // Operand registers, tile counter and latency counter.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      a_r       <= {AW{1'b0}};
      b_r       <= {BW{1'b0}};
      tile_r    <= {TW{1'b0}};
      lat_cnt_r <= {LW{1'b0}};
    end else begin
      if (accept_s) begin
        a_r    <= IN_DATA;
        tile_r <= {TW{1'b0}};
      end else if (advance_s && (tile_r != LAST_TILE)) begin
        // advance_s only fires for a non-final tile; the compare keeps
        // the counter inside 0..TILES-1 even if that ever changes.
        tile_r <= tile_r + TILE_ONE;
      end

      if (wtake_s) begin
        b_r <= W_DATA;
      end

      if (state_r == ST_ISSUE) begin
        lat_cnt_r <= LAT_LOAD;
      end else if ((state_r == ST_WAIT) && (lat_cnt_r != {LW{1'b0}})) begin
        lat_cnt_r <= lat_cnt_r - LAT_ONE;
      end
    end
  end

  // Result registers; loaded only on the final WAIT edge, then held through EMIT.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_data_r <= {OW{1'b0}};
      out_tile_r <= {TW{1'b0}};
      out_last_r <= 1'b0;
    end else if (capture_s) begin
      out_data_r <= DP_O;
      out_tile_r <= tile_r;
      out_last_r <= (tile_r == LAST_TILE);
    end
  end

  assign IN_READY  = in_ready_r;
  assign BUSY      = busy_r;
  assign W_REQ     = w_req_r;
  assign W_ADDR    = tile_r;
  assign DP_START  = dp_start_r;
  assign DP_A      = a_r;
  assign DP_B      = b_r;
  assign OUT_VALID = out_valid_r;
  assign OUT_DATA  = out_data_r;
  assign OUT_TILE  = out_tile_r;
  assign OUT_LAST  = out_last_r;

endmodule

// File: tb/tb_neuron_scheduler.sv
// ---------------------------------------------------------------------------
// tb_neuron_scheduler
//
// Directed bench for neuron_scheduler with DWIDTH=8, IDIM=1, ODIM=2,
// TILES=2, LATENCY=3. The datapath is modelled as a three-stage registered
// outer product launched by DP_START, so DP_O carries the product only in
// the cycle the scheduler is expected to capture it.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_neuron_scheduler;

  localparam int DWIDTH  = 8;
  localparam int IDIM    = 1;
  localparam int ODIM    = 2;
  localparam int TILES   = 2;
  localparam int LATENCY = 3;

  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  IN_DATA;
  logic        W_REQ;
  logic [0:0]  W_ADDR;
  logic        W_VALID;
  logic [15:0] W_DATA;
  logic        DP_START;
  logic [7:0]  DP_A;
  logic [15:0] DP_B;
  logic [15:0] DP_O;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] OUT_DATA;
  logic [0:0]  OUT_TILE;
  logic        OUT_LAST;
  logic        BUSY;

  int errors = 0;
  int checks = 0;

  neuron_scheduler #(
    .DWIDTH (DWIDTH),
    .IDIM   (IDIM),
    .ODIM   (ODIM),
    .TILES  (TILES),
    .LATENCY(LATENCY)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET_N  (RESET_N),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_DATA  (IN_DATA),
    .W_REQ    (W_REQ),
    .W_ADDR   (W_ADDR),
    .W_VALID  (W_VALID),
    .W_DATA   (W_DATA),
    .DP_START (DP_START),
    .DP_A     (DP_A),
    .DP_B     (DP_B),
    .DP_O     (DP_O),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_DATA (OUT_DATA),
    .OUT_TILE (OUT_TILE),
    .OUT_LAST (OUT_LAST),
    .BUSY     (BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  // Datapath model: element j of the result is A * B[j], three registered stages.
  logic [15:0] prod_s;
  logic [15:0] p1_r, p2_r, p3_r;
  always_comb begin
    prod_s[7:0]  = DP_A * DP_B[7:0];
    prod_s[15:8] = DP_A * DP_B[15:8];
  end
  always_ff @(posedge CLOCK) begin
    p1_r <= DP_START ? prod_s : 16'h0000;
    p2_r <= p1_r;
    p3_r <= p2_r;
  end
  assign DP_O = p3_r;

  task automatic step;
    @(negedge CLOCK);
  endtask

  // Present a job for one cycle; returns at the first FETCH cycle.
  task automatic start_job(input logic [7:0] a);
    IN_VALID = 1'b1;
    IN_DATA  = a;
    step();
    IN_VALID = 1'b0;
  endtask

  // Step until OUT_VALID is seen or the budget runs out.
  task automatic wait_out(input int limit, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (n < limit) begin
      if (OUT_VALID) begin
        ok = 1'b1;
        break;
      end
      step();
      n++;
    end
  endtask

  // Finish whatever job is running with zero-wait handshakes.
  task automatic drain;
    for (int i = 0; i < 100; i++) begin
      if (!BUSY && IN_READY) break;
      W_VALID   = W_REQ;
      W_DATA    = 16'h1111;
      OUT_READY = 1'b1;
      step();
    end
    W_VALID = 1'b0;
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: BUSY=%b want 0", BUSY);
    end
  endtask

  task automatic test_reset;
    RESET_N   = 1'b0;
    IN_VALID  = 1'b0;
    IN_DATA   = 8'h00;
    W_VALID   = 1'b0;
    W_DATA    = 16'h0000;
    OUT_READY = 1'b1;
    step();
    step();
    checks++;
    if ({IN_READY, BUSY, W_REQ, DP_START, OUT_VALID, OUT_LAST} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: rdy,busy,wreq,start,ov,last=%b want 100000",
               {IN_READY, BUSY, W_REQ, DP_START, OUT_VALID, OUT_LAST});
    end
    checks++;
    if ({W_ADDR, OUT_TILE} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idx: waddr=%b tile=%b want 0 0", W_ADDR, OUT_TILE);
    end
    checks++;
    if ({OUT_DATA, DP_A, DP_B} !== 40'h0) begin
      errors++;
      $display("FAIL reset_data: out=%h a=%h b=%h want 0", OUT_DATA, DP_A, DP_B);
    end
    RESET_N = 1'b1;
    step();
    checks++;
    if ({IN_READY, BUSY} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: rdy,busy=%b want 10", {IN_READY, BUSY});
    end
  endtask

  task automatic test_basic;
    bit ok;
    int n;
    OUT_READY = 1'b1;
    start_job(8'h03);                                  // t+1
    checks++;
    if ({W_REQ, BUSY, IN_READY, W_ADDR} !== 4'b1100) begin
      errors++;
      $display("FAIL basic_fetch0: wreq,busy,rdy,addr=%b want 1100",
               {W_REQ, BUSY, IN_READY, W_ADDR});
    end
    W_VALID = 1'b1;
    W_DATA  = 16'h0201;
    step();                                            // t+2
    W_VALID = 1'b0;
    checks++;
    if ({DP_START, DP_A, DP_B} !== {1'b1, 8'h03, 16'h0201}) begin
      errors++;
      $display("FAIL basic_issue0: start=%b a=%h b=%h want 1 03 0201", DP_START, DP_A, DP_B);
    end
    for (int i = 0; i < 3; i++) begin                  // t+3..t+5
      step();
      checks++;
      if ({OUT_VALID, DP_START} !== 2'b00) begin
        errors++;
        $display("FAIL basic_wait%0d: ov,start=%b want 00", i, {OUT_VALID, DP_START});
      end
    end
    step();                                            // t+6
    checks++;
    if ({OUT_VALID, OUT_DATA, OUT_TILE, OUT_LAST} !== {1'b1, 16'h0603, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_out0: ov=%b data=%h tile=%b last=%b want 1 0603 0 0",
               OUT_VALID, OUT_DATA, OUT_TILE, OUT_LAST);
    end
    step();                                            // t+7
    checks++;
    if ({W_REQ, W_ADDR, OUT_VALID} !== 3'b110) begin
      errors++;
      $display("FAIL basic_fetch1: wreq,addr,ov=%b want 110", {W_REQ, W_ADDR, OUT_VALID});
    end
    W_VALID = 1'b1;
    W_DATA  = 16'h0504;
    step();                                            // t+8
    W_VALID = 1'b0;
    checks++;
    if (DP_START !== 1'b1) begin
      errors++;
      $display("FAIL basic_issue1: start=%b want 1", DP_START);
    end
    wait_out(10, ok, n);
    checks++;
    if (!ok || n != 4) begin
      errors++;
      $display("FAIL basic_lat1: found=%0d cycles=%0d want 1 4", ok, n);
    end
    checks++;
    if ({OUT_DATA, OUT_TILE, OUT_LAST} !== {16'h0F0C, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL basic_out1: data=%h tile=%b last=%b want 0F0C 1 1", OUT_DATA, OUT_TILE, OUT_LAST);
    end
    step();
    checks++;
    if ({IN_READY, BUSY, OUT_VALID, W_REQ} !== 4'b1000) begin
      errors++;
      $display("FAIL basic_idle: rdy,busy,ov,wreq=%b want 1000", {IN_READY, BUSY, OUT_VALID, W_REQ});
    end
  endtask

  task automatic test_wait_fetch;
    int n;
    int starts;
    OUT_READY = 1'b1;
    start_job(8'h02);                                  // t+1
    for (int i = 0; i < 5; i++) begin                  // t+1..t+5, no W_VALID
      checks++;
      if ({W_REQ, W_ADDR, DP_START} !== 3'b100) begin
        errors++;
        $display("FAIL wf_hold%0d: wreq,addr,start=%b want 100", i, {W_REQ, W_ADDR, DP_START});
      end
      step();
    end
    W_VALID = 1'b1;                                    // t+6
    W_DATA  = 16'h0403;
    step();                                            // t+7
    W_VALID = 1'b0;
    checks++;
    if ({DP_START, W_REQ, DP_B} !== {1'b1, 1'b0, 16'h0403}) begin
      errors++;
      $display("FAIL wf_issue: start=%b wreq=%b b=%h want 1 0 0403", DP_START, W_REQ, DP_B);
    end
    starts = 0;
    n = 0;
    while (!OUT_VALID && n < 20) begin
      step();
      n++;
      if (DP_START) starts++;
    end
    checks++;
    if (OUT_VALID !== 1'b1 || n != 4 || starts != 0) begin
      errors++;
      $display("FAIL wf_once: ov=%b cycles=%0d extra_starts=%0d want 1 4 0", OUT_VALID, n, starts);
    end
    checks++;
    if ({OUT_DATA, OUT_TILE, OUT_LAST} !== {16'h0806, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wf_out: data=%h tile=%b last=%b want 0806 0 0", OUT_DATA, OUT_TILE, OUT_LAST);
    end
    drain();
  endtask

  task automatic test_backpressure;
    bit ok;
    int n;
    OUT_READY = 1'b0;
    start_job(8'h01);
    W_VALID = 1'b1;
    W_DATA  = 16'h0706;
    step();                                            // t+2
    W_VALID = 1'b0;
    wait_out(10, ok, n);
    checks++;
    if (!ok || n != 4) begin
      errors++;
      $display("FAIL bp_lat: found=%0d cycles=%0d want 1 4", ok, n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({OUT_VALID, OUT_DATA, OUT_TILE, OUT_LAST, W_REQ} !== {1'b1, 16'h0706, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: ov=%b data=%h tile=%b last=%b wreq=%b want 1 0706 0 0 0",
                 i, OUT_VALID, OUT_DATA, OUT_TILE, OUT_LAST, W_REQ);
      end
      step();
    end
    checks++;
    if ({OUT_VALID, W_REQ} !== 2'b10) begin
      errors++;
      $display("FAIL bp_still: ov,wreq=%b want 10", {OUT_VALID, W_REQ});
    end
    OUT_READY = 1'b1;
    step();
    checks++;
    if ({W_REQ, W_ADDR, OUT_VALID} !== 3'b110) begin
      errors++;
      $display("FAIL bp_next: wreq,addr,ov=%b want 110", {W_REQ, W_ADDR, OUT_VALID});
    end
    drain();
  endtask

  task automatic test_busy_in_valid;
    int  rdy_bad;
    int  a_bad;
    bit  found;
    OUT_READY = 1'b1;
    IN_VALID  = 1'b1;
    IN_DATA   = 8'h05;
    step();                                            // job 1 accepted
    IN_DATA   = 8'h09;                                 // IN_VALID stays high
    rdy_bad = 0;
    a_bad   = 0;
    found   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (IN_READY) rdy_bad++;
      if (DP_A !== 8'h05) a_bad++;
      W_VALID = W_REQ;
      W_DATA  = 16'h0101;
      if (OUT_VALID && OUT_LAST) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!found || rdy_bad != 0 || a_bad != 0) begin
      errors++;
      $display("FAIL biv_busy: last_seen=%0d ready_high=%0d a_changed=%0d want 1 0 0",
               found, rdy_bad, a_bad);
    end
    checks++;
    if (OUT_DATA !== 16'h0505) begin
      errors++;
      $display("FAIL biv_out: data=%h want 0505", OUT_DATA);
    end
    step();                                            // back in IDLE
    checks++;
    if ({IN_READY, BUSY, OUT_VALID} !== 3'b100) begin
      errors++;
      $display("FAIL biv_idle: rdy,busy,ov=%b want 100", {IN_READY, BUSY, OUT_VALID});
    end
    step();                                            // job 2 fetching
    checks++;
    if ({W_REQ, W_ADDR, IN_READY, DP_A} !== {1'b1, 1'b0, 1'b0, 8'h09}) begin
      errors++;
      $display("FAIL biv_job2: wreq=%b addr=%b rdy=%b a=%h want 1 0 0 09", W_REQ, W_ADDR, IN_READY, DP_A);
    end
    IN_VALID = 1'b0;
    drain();
  endtask

  task automatic test_reset_wait;
    bit ok;
    int n;
    int bad;
    OUT_READY = 1'b1;
    start_job(8'h03);
    W_VALID = 1'b1;
    W_DATA  = 16'h0201;
    step();                                            // ISSUE
    W_VALID = 1'b0;
    step();                                            // WAIT
    checks++;
    if ({BUSY, DP_START, W_REQ, OUT_VALID} !== 4'b1000) begin
      errors++;
      $display("FAIL rw_inwait: busy,start,wreq,ov=%b want 1000", {BUSY, DP_START, W_REQ, OUT_VALID});
    end
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({IN_READY, BUSY, W_REQ, DP_START, OUT_VALID, OUT_LAST, OUT_TILE, W_ADDR} !== 8'b10000000) begin
      errors++;
      $display("FAIL rw_ctrl: rdy,busy,wreq,start,ov,last,tile,addr=%b want 10000000",
               {IN_READY, BUSY, W_REQ, DP_START, OUT_VALID, OUT_LAST, OUT_TILE, W_ADDR});
    end
    checks++;
    if ({OUT_DATA, DP_A, DP_B} !== 40'h0) begin
      errors++;
      $display("FAIL rw_data: out=%h a=%h b=%h want 0", OUT_DATA, DP_A, DP_B);
    end
    step();
    RESET_N = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (W_REQ || DP_START || OUT_VALID || BUSY) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rw_quiet: active_cycles=%0d want 0", bad);
    end
    start_job(8'h01);
    checks++;
    if ({W_REQ, W_ADDR} !== 2'b10) begin
      errors++;
      $display("FAIL rw_restart: wreq,addr=%b want 10", {W_REQ, W_ADDR});
    end
    W_VALID = 1'b1;
    W_DATA  = 16'h0A0B;
    step();
    W_VALID = 1'b0;
    wait_out(10, ok, n);
    checks++;
    if (!ok || n != 4 || {OUT_DATA, OUT_TILE, OUT_LAST} !== {16'h0A0B, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rw_out: found=%0d cycles=%0d data=%h tile=%b last=%b want 1 4 0A0B 0 0",
               ok, n, OUT_DATA, OUT_TILE, OUT_LAST);
    end
    drain();
  endtask

  task automatic test_spurious;
    int bad;
    OUT_READY = 1'b1;
    start_job(8'h02);
    W_VALID = 1'b1;
    W_DATA  = 16'h0302;
    step();                                            // ISSUE
    W_DATA  = 16'hAAAA;                                // W_VALID stays high
    bad = 0;
    for (int i = 0; i < 3; i++) begin                  // WAIT cycles
      step();
      if (DP_B !== 16'h0302 || DP_START !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sp_wait: disturbed_cycles=%0d b=%h want 0 0302", bad, DP_B);
    end
    step();                                            // EMIT
    W_VALID = 1'b0;
    checks++;
    if ({OUT_VALID, OUT_DATA, DP_B} !== {1'b1, 16'h0604, 16'h0302}) begin
      errors++;
      $display("FAIL sp_out: ov=%b data=%h b=%h want 1 0604 0302", OUT_VALID, OUT_DATA, DP_B);
    end
    drain();                                           // final tile B = 1111
    W_VALID = 1'b1;
    W_DATA  = 16'h5555;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (DP_B !== 16'h1111 || W_REQ || BUSY || DP_START) bad++;
    end
    W_VALID = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sp_idle: disturbed_cycles=%0d b=%h want 0 1111", bad, DP_B);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_fetch();
    test_backpressure();
    test_busy_in_valid();
    test_reset_wait();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/neuron_scheduler.md
NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

Interface
REQ-001 Parameter DWIDTH, default 32: element width in bits.
REQ-002 Parameter IDIM, default 1: input-vector elements per job.
REQ-003 Parameter ODIM, default 2: weight elements per tile.
REQ-004 Parameter TILES, default 4: weight tiles per job (>=1).
REQ-005 Parameter LATENCY, default 4: datapath cycles from DP_START to valid DP_O (>=1).
REQ-006 Port CLOCK, input, 1: sole clock, rising edge.
REQ-007 Port RESET_N, input, 1: asynchronous, active-low reset.
REQ-008 Port IN_VALID, input, 1: job input vector valid.
REQ-009 Port IN_READY, output, 1: scheduler can accept a job.
REQ-010 Port IN_DATA, input, DWIDTH*IDIM: job input vector.
REQ-011 Port W_REQ, output, 1: weight tile fetch request.
REQ-012 Port W_ADDR, output, max(1,clog2(TILES)): requested tile index.
REQ-013 Port W_VALID, input, 1: weight tile returned.
REQ-014 Port W_DATA, input, DWIDTH*ODIM: weight tile.
REQ-015 Port DP_START, output, 1: datapath start pulse.
REQ-016 Port DP_A, output, DWIDTH*IDIM: datapath operand A.
REQ-017 Port DP_B, output, DWIDTH*ODIM: datapath operand B.
REQ-018 Port DP_O, input, DWIDTH*IDIM*ODIM: datapath result.
REQ-019 Port OUT_VALID, output, 1: tile result valid.
REQ-020 Port OUT_READY, input, 1: downstream accepts result.
REQ-021 Port OUT_DATA, output, DWIDTH*IDIM*ODIM: registered tile result.
REQ-022 Port OUT_TILE, output, max(1,clog2(TILES)): tile index of OUT_DATA.
REQ-023 Port OUT_LAST, output, 1: OUT_DATA is the final tile of the job.
REQ-024 Port BUSY, output, 1: high in every state except IDLE.

Function
REQ-025 The FSM SHALL have states IDLE, FETCH, ISSUE, WAIT and EMIT.
REQ-026 IDLE: IN_READY=1; on IN_VALID&IN_READY, latch IN_DATA into the A register, clear the tile counter, go to FETCH.
REQ-027 FETCH: W_REQ=1, W_ADDR=tile counter, held stable until W_VALID; on W_VALID, latch W_DATA into the B register and go to ISSUE.
REQ-028 W_VALID outside FETCH SHALL be ignored; W_VALID in the FETCH entry cycle SHALL be accepted (zero-wait fetch).
REQ-029 ISSUE: DP_START=1 for exactly one cycle, load the latency counter with LATENCY, go to WAIT.
REQ-030 WAIT: lasts exactly LATENCY cycles; at the clock edge ending the last WAIT cycle, DP_O SHALL be captured into OUT_DATA, the tile counter into OUT_TILE, and (tile==TILES-1) into OUT_LAST; then go to EMIT.
REQ-031 EMIT: OUT_VALID=1; OUT_DATA, OUT_TILE and OUT_LAST SHALL stay stable until OUT_READY.
REQ-032 On OUT_VALID&OUT_READY: if OUT_LAST, go to IDLE; else increment the tile counter and go to FETCH.
REQ-033 DP_A and DP_B SHALL be driven continuously from the A and B registers, and SHALL be stable from ISSUE through WAIT.
REQ-034 Timing with zero-wait handshakes: job accepted at cycle t -> W_REQ at t+1 -> DP_START at t+2 -> OUT_VALID at t+3+LATENCY.
REQ-035 IN_READY SHALL be 0 outside IDLE; IN_VALID while busy SHALL have no effect.
REQ-036 With TILES=1, the first EMIT SHALL assert OUT_LAST=1 and return to IDLE.
REQ-037 The tile counter SHALL never exceed TILES-1 (no wrap within a job).

Reset
REQ-038 On RESET_N low, asynchronously: state=IDLE; IN_READY=1; W_REQ=0; W_ADDR=0; DP_START=0; OUT_VALID=0; OUT_LAST=0; OUT_TILE=0; BUSY=0; OUT_DATA, A and B registers=0.
REQ-039 Reset asserted in any state SHALL abort the job with no further W_REQ, DP_START or OUT_VALID until a new job is accepted.

Verification (DWIDTH=8, IDIM=1, ODIM=2, TILES=2, LATENCY=3; bench models the datapath as 3-cycle registered outer product)
REQ-040 Job IN_DATA=0x03, zero-wait tiles {0x02,0x01}, {0x05,0x04} -> OUT_DATA 0x0603 (tile 0, LAST=0) then 0x0F0C (tile 1, LAST=1); first OUT_VALID 6 cycles after acceptance.
REQ-041 W_VALID delayed 5 cycles -> W_REQ and W_ADDR held stable throughout; DP_START fires exactly once, the cycle after W_VALID.
REQ-042 OUT_READY low for 4 cycles in EMIT -> OUT_DATA, OUT_TILE and OUT_LAST stable; no W_REQ until the handshake completes.
REQ-043 IN_VALID held high during a job -> IN_READY=0; the second job is accepted only in the cycle after the final-tile handshake returns to IDLE.
REQ-044 RESET_N pulsed low during WAIT -> all outputs at reset values immediately; no OUT_VALID afterwards; a subsequent job completes normally from tile 0.
REQ-045 Spurious W_VALID during IDLE and WAIT -> ignored; B register unchanged.
